// File: rtl/result_unloader.sv
// Captures result rows from the systolic array into a SIZE x SIZE buffer and
// drains the valid region onto the bus as packed words with a valid/ready handshake.
module result_unloader #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 unload_start,
    input  logic [$clog2(SIZE)-1:0]              valid_row_num,
    input  logic [$clog2(SIZE)-1:0]              valid_col_num,
    input  logic                                 result_in_valid,
    input  logic [SIZE-1:0][DATA_WIDTH-1:0]      result_in,
    output logic [BUS_WIDTH-1:0]                 result_data_out,
    output logic [$clog2(SIZE*SIZE)-1:0]         result_addr,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic                                 unload_busy,
    output logic                                 unload_done
);

    localparam int EPW = BUS_WIDTH / DATA_WIDTH;
    localparam int RW  = $clog2(SIZE);
    localparam int CW  = RW + 1;
    localparam int AW  = $clog2(SIZE * SIZE);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t                          state;
    logic [CW-1:0]                   rows;
    logic [CW-1:0]                   cols;
    logic [CW-1:0]                   r_cnt;
    logic [CW-1:0]                   d_row;
    logic [CW-1:0]                   col_base;
    logic [SIZE-1:0][DATA_WIDTH-1:0] buffer [SIZE];

    logic [CW-1:0]                   nxt_row;
    logic [CW-1:0]                   nxt_col;
    logic                            last_word;
    logic [SIZE-1:0][DATA_WIDTH-1:0] src_row;
    logic [BUS_WIDTH-1:0]            nxt_word;
    logic [AW-1:0]                   nxt_addr;

    // Elements are signed but only passed through, so packing ignores sign.
    function automatic logic [BUS_WIDTH-1:0] pack_word(
        input logic [SIZE-1:0][DATA_WIDTH-1:0] row,
        input int                              base,
        input int                              ncols
    );
        logic [RW-1:0] idx;
        pack_word = '0;
        for (int k = 0; k < EPW; k++) begin
            idx = RW'(base + k);
            if ((base + k) < ncols && (base + k) < SIZE)
                pack_word[k*DATA_WIDTH +: DATA_WIDTH] = row[idx];
        end
    endfunction

    // The first word is prepared while the last row is still being written,
    // so a single-row operation must take its data straight from result_in.
    always_comb begin
        nxt_row   = '0;
        nxt_col   = '0;
        last_word = 1'b0;
        src_row   = buffer[0];
        if (state == CAPTURE) begin
            if (r_cnt == '0)
                src_row = result_in;
        end else begin
            if (int'(col_base) + EPW >= int'(cols)) begin
                if (d_row == rows - CW'(1))
                    last_word = 1'b1;
                else
                    nxt_row = d_row + CW'(1);
            end else begin
                nxt_row = d_row;
                nxt_col = col_base + CW'(EPW);
            end
            src_row = buffer[nxt_row[RW-1:0]];
        end
        nxt_word = pack_word(src_row, int'(nxt_col), int'(cols));
        nxt_addr = AW'(int'(nxt_row) * SIZE + int'(nxt_col));
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE && result_in_valid)
            buffer[r_cnt[RW-1:0]] <= result_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rows            <= '0;
            cols            <= '0;
            r_cnt           <= '0;
            d_row           <= '0;
            col_base        <= '0;
            result_data_out <= '0;
            result_addr     <= '0;
            result_valid    <= 1'b0;
            unload_busy     <= 1'b0;
            unload_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    unload_done <= 1'b0;
                    if (unload_start) begin
                        rows        <= CW'(valid_row_num) + CW'(1);
                        cols        <= CW'(valid_col_num) + CW'(1);
                        r_cnt       <= '0;
                        unload_busy <= 1'b1;
                        state       <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (result_in_valid) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == rows - CW'(1)) begin
                            d_row           <= '0;
                            col_base        <= '0;
                            result_data_out <= nxt_word;
                            result_addr     <= nxt_addr;
                            result_valid    <= 1'b1;
                            state           <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (result_valid && result_ready) begin
                        if (last_word) begin
                            result_valid <= 1'b0;
                            unload_done  <= 1'b1;
                            state        <= DONE;
                        end else begin
                            d_row           <= nxt_row;
                            col_base        <= nxt_col;
                            result_data_out <= nxt_word;
                            result_addr     <= nxt_addr;
                        end
                    end
                end
                DONE: begin
                    unload_done <= 1'b0;
                    unload_busy <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: capture patterns, packing, backpressure,
// abort by reset and stale-input rejection.
module tb_result_unloader;

    logic             clk = 1'b0;
    logic             rst;
    logic             unload_start;
    logic [3:0]       valid_row_num;
    logic [3:0]       valid_col_num;
    logic             result_in_valid;
    logic [15:0][7:0] result_in;
    logic [31:0]      result_data_out;
    logic [7:0]       result_addr;
    logic             result_valid;
    logic             result_ready;
    logic             unload_busy;
    logic             unload_done;

    logic [7:0]  mat [16][16];
    logic [31:0] got_data [$];
    logic [7:0]  got_addr [$];
    int          stall_err;
    int          valid_cycles;
    logic        timed_out;
    logic        done_at_end;
    logic        busy_at_end;
    logic        done_after;
    logic        busy_after;
    int          checks = 0;
    int          passed = 0;

    result_unloader dut (
        .clk             (clk),
        .rst             (rst),
        .unload_start    (unload_start),
        .valid_row_num   (valid_row_num),
        .valid_col_num   (valid_col_num),
        .result_in_valid (result_in_valid),
        .result_in       (result_in),
        .result_data_out (result_data_out),
        .result_addr     (result_addr),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .unload_busy     (unload_busy),
        .unload_done     (unload_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input int r, input int w, input int ncols);
        exp_word = '0;
        for (int k = 0; k < 4; k++)
            if (w*4 + k < ncols)
                exp_word[k*8 +: 8] = mat[r][w*4 + k];
    endfunction

    task automatic fill(input int seed);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mat[r][c] = 8'(r*16 + c + seed);
    endtask

    task automatic start_op(input int vr, input int vc);
        @(negedge clk);
        valid_row_num = 4'(vr);
        valid_col_num = 4'(vc);
        unload_start  = 1'b1;
        @(negedge clk);
        unload_start  = 1'b0;
    endtask

    // Slot i of the pattern carries the next matrix row when bit i is set.
    task automatic send_rows(input int len, input logic [15:0] pattern);
        int r;
        r = 0;
        for (int i = 0; i < len; i++) begin
            result_in_valid = pattern[i];
            for (int c = 0; c < 16; c++)
                result_in[c] = pattern[i] ? mat[r][c] : 8'hEE;
            if (pattern[i]) r++;
            @(negedge clk);
        end
        result_in_valid = 1'b0;
    endtask

    task automatic collect(input bit random_ready, input int start_at);
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [7:0]  prev_addr;
        logic        finished;
        got_data.delete();
        got_addr.delete();
        stall_err    = 0;
        valid_cycles = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        prev_addr    = '0;
        finished     = 1'b0;
        done_at_end  = 1'b0;
        busy_at_end  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            unload_start = (i == start_at);
            if (result_valid) begin
                valid_cycles++;
                if (prev_stall && (result_data_out !== prev_data || result_addr !== prev_addr))
                    stall_err++;
                result_ready = random_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
                if (result_ready) begin
                    got_data.push_back(result_data_out);
                    got_addr.push_back(result_addr);
                end
                prev_stall = !result_ready;
                prev_data  = result_data_out;
                prev_addr  = result_addr;
            end else if (got_data.size() > 0) begin
                done_at_end = unload_done;
                busy_at_end = unload_busy;
                finished    = 1'b1;
                break;
            end
            @(negedge clk);
        end
        timed_out    = !finished;
        unload_start = 1'b0;
        result_ready = 1'b0;
        @(negedge clk);
        done_after = unload_done;
        busy_after = unload_busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", result_valid); else passed++;
        checks++; if (unload_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", unload_busy); else passed++;
        checks++; if (unload_done !== 1'b0) $display("FAIL reset_done got %b want 0", unload_done); else passed++;
        checks++; if (result_data_out !== 32'h0) $display("FAIL reset_data got %h want 0", result_data_out); else passed++;
        checks++; if (result_addr !== 8'h0) $display("FAIL reset_addr got %h want 0", result_addr); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_full();
        fill(0);
        start_op(15, 15);
        checks++; if (unload_busy !== 1'b1) $display("FAIL full_busy got %b want 1", unload_busy); else passed++;
        send_rows(16, 16'hFFFF);
        collect(1'b0, -1);
        checks++; if (timed_out !== 1'b0) $display("FAIL full_timeout got %b want 0", timed_out); else passed++;
        checks++; if (got_data.size() != 64) $display("FAIL full_count got %0d want 64", got_data.size()); else passed++;
        checks++; if (valid_cycles != 64) $display("FAIL full_cycles got %0d want 64", valid_cycles); else passed++;
        if (got_data.size() == 64) begin
            checks++; if (got_data[0] !== 32'h03020100) $display("FAIL full_word0 got %h want 03020100", got_data[0]); else passed++;
            checks++; if (got_data[4] !== 32'h13121110) $display("FAIL full_word4 got %h want 13121110", got_data[4]); else passed++;
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (got_addr[i] !== 8'(i*4) || got_data[i] !== exp_word(i/4, i%4, 16))
                    $display("FAIL full_word[%0d] got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_word(i/4, i%4, 16), 8'(i*4));
                else passed++;
            end
        end
        checks++; if (done_at_end !== 1'b1) $display("FAIL full_done got %b want 1", done_at_end); else passed++;
        checks++; if (busy_at_end !== 1'b1) $display("FAIL full_busy_done got %b want 1", busy_at_end); else passed++;
        checks++; if (done_after !== 1'b0 || busy_after !== 1'b0) $display("FAIL full_idle got done=%b busy=%b want 0/0", done_after, busy_after); else passed++;
    endtask

    task automatic test_partial();
        int exp_a [6];
        exp_a = '{0, 4, 16, 20, 32, 36};
        fill(7);
        start_op(2, 4);
        send_rows(3, 16'h0007);
        collect(1'b0, -1);
        checks++; if (timed_out !== 1'b0) $display("FAIL part_timeout got %b want 0", timed_out); else passed++;
        checks++; if (got_data.size() != 6) $display("FAIL part_count got %0d want 6", got_data.size()); else passed++;
        if (got_data.size() == 6) begin
            checks++; if (got_data[3] !== {24'h0, mat[1][4]}) $display("FAIL part_row1w1 got %h want %h", got_data[3], {24'h0, mat[1][4]}); else passed++;
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_addr[i] !== 8'(exp_a[i]) || got_data[i] !== exp_word(i/2, i%2, 5))
                    $display("FAIL part_word[%0d] got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_word(i/2, i%2, 5), 8'(exp_a[i]));
                else passed++;
            end
        end
        checks++; if (done_at_end !== 1'b1) $display("FAIL part_done got %b want 1", done_at_end); else passed++;
    endtask

    task automatic test_backpressure();
        fill(33);
        start_op(4, 9);
        send_rows(5, 16'h001F);
        collect(1'b1, -1);
        checks++; if (timed_out !== 1'b0) $display("FAIL bp_timeout got %b want 0", timed_out); else passed++;
        checks++; if (stall_err != 0) $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err); else passed++;
        checks++; if (got_data.size() != 15) $display("FAIL bp_count got %0d want 15", got_data.size()); else passed++;
        if (got_data.size() == 15) begin
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (got_addr[i] !== 8'((i/3)*16 + (i%3)*4) || got_data[i] !== exp_word(i/3, i%3, 10))
                    $display("FAIL bp_word[%0d] got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_word(i/3, i%3, 10), 8'((i/3)*16 + (i%3)*4));
                else passed++;
            end
        end
        checks++; if (done_at_end !== 1'b1) $display("FAIL bp_done got %b want 1", done_at_end); else passed++;
    endtask

    task automatic test_gaps();
        fill(101);
        start_op(3, 7);
        send_rows(7, 16'b1011001);
        checks++; if (result_valid !== 1'b1) $display("FAIL gap_drain_start got %b want 1", result_valid); else passed++;
        collect(1'b0, -1);
        checks++; if (got_data.size() != 8) $display("FAIL gap_count got %0d want 8", got_data.size()); else passed++;
        if (got_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_addr[i] !== 8'((i/2)*16 + (i%2)*4) || got_data[i] !== exp_word(i/2, i%2, 8))
                    $display("FAIL gap_word[%0d] got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_word(i/2, i%2, 8), 8'((i/2)*16 + (i%2)*4));
                else passed++;
            end
        end
    endtask

    task automatic test_abort();
        int done_seen;
        fill(55);
        start_op(3, 15);
        send_rows(4, 16'h000F);
        collect(1'b0, 5);
        checks++; if (got_data.size() != 16) $display("FAIL midstart_count got %0d want 16", got_data.size()); else passed++;
        if (got_data.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got_addr[i] !== 8'(i*4) || got_data[i] !== exp_word(i/4, i%4, 16))
                    $display("FAIL midstart_word[%0d] got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_word(i/4, i%4, 16), 8'(i*4));
                else passed++;
            end
        end
        checks++; if (busy_after !== 1'b0) $display("FAIL midstart_idle got busy=%b want 0", busy_after); else passed++;

        start_op(3, 15);
        send_rows(4, 16'h000F);
        result_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (result_valid !== 1'b0) $display("FAIL abort_valid got %b want 0", result_valid); else passed++;
        checks++; if (unload_busy !== 1'b0) $display("FAIL abort_busy got %b want 0", unload_busy); else passed++;
        done_seen = 0;
        @(negedge clk);
        rst = 1'b0;
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (unload_done === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks++; if (done_seen != 0) $display("FAIL abort_done got %0d pulses want 0", done_seen); else passed++;

        fill(200);
        start_op(0, 0);
        send_rows(1, 16'h0001);
        collect(1'b0, -1);
        checks++; if (got_data.size() != 1) $display("FAIL one_count got %0d want 1", got_data.size()); else passed++;
        if (got_data.size() == 1) begin
            checks++; if (got_addr[0] !== 8'h0) $display("FAIL one_addr got %h want 00", got_addr[0]); else passed++;
            checks++; if (got_data[0] !== {24'h0, mat[0][0]}) $display("FAIL one_data got %h want %h", got_data[0], {24'h0, mat[0][0]}); else passed++;
        end
    endtask

    task automatic test_stale_row();
        result_in_valid = 1'b1;
        for (int c = 0; c < 16; c++) result_in[c] = 8'hEE;
        repeat (3) @(negedge clk);
        result_in_valid = 1'b0;
        fill(77);
        start_op(1, 1);
        send_rows(4, 16'b1010);
        collect(1'b0, -1);
        checks++; if (got_data.size() != 2) $display("FAIL stale_count got %0d want 2", got_data.size()); else passed++;
        if (got_data.size() == 2) begin
            checks++; if (got_data[0] !== {16'h0, mat[0][1], mat[0][0]}) $display("FAIL stale_row0 got %h want %h", got_data[0], {16'h0, mat[0][1], mat[0][0]}); else passed++;
            checks++; if (got_data[1] !== {16'h0, mat[1][1], mat[1][0]} || got_addr[1] !== 8'd16)
                $display("FAIL stale_row1 got %h@%h want %h@10", got_data[1], got_addr[1], {16'h0, mat[1][1], mat[1][0]});
            else passed++;
        end
    endtask

    initial begin
        rst             = 1'b1;
        unload_start    = 1'b0;
        valid_row_num   = '0;
        valid_col_num   = '0;
        result_in_valid = 1'b0;
        result_in       = '0;
        result_ready    = 1'b0;
        test_reset();
        test_full();
        test_partial();
        test_backpressure();
        test_gaps();
        test_abort();
        test_stale_row();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
